axi_eth_tx_sfifo: RTL

Single-clock, store-and-forward transmit frame FIFO between the TX datapath and the 10G MAC `tx_axis_mac` interface, parametrised in data width, buffer depth and in-flight frame count. It is the successor to the fixed 64-bit dual-FIFO outbound path. A frame is released to the MAC only once its last beat is stored, so the MAC never sees an underrun. Frames marked bad by the source, or frames that overflow the buffer, are discarded in full and counted.

---
 rtl/axi_eth_tx_sfifo.sv | 123 ++++++++++++
 1 files changed

// File: rtl/axi_eth_tx_sfifo.sv
// axi_eth_tx_sfifo: store-and-forward TX frame FIFO (s_axis ingress -> tx_axis_mac egress, drop counter, fill level)
module axi_eth_tx_sfifo #(
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_DEPTH_LOG2  = 9,
  parameter int C_FRAMES_LOG2 = 4
) (
  input  logic                      tx_clk,
  input  logic                      tx_reset,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tuser,
  output logic                      s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   tx_axis_mac_tdata,
  output logic [C_DATA_WIDTH/8-1:0] tx_axis_mac_tkeep,
  output logic                      tx_axis_mac_tvalid,
  output logic                      tx_axis_mac_tlast,
  output logic                      tx_axis_mac_tuser,
  input  logic                      tx_axis_mac_tready,
  output logic [15:0]               frame_drop_cnt,
  output logic [C_DEPTH_LOG2:0]     fifo_level
);
  localparam int KW = C_DATA_WIDTH / 8;
  localparam int EW = C_DATA_WIDTH + KW + 1;
  localparam int AW = C_DEPTH_LOG2;
  localparam int FW = C_FRAMES_LOG2;
  localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ALMOST = {1'b0, {AW{1'b1}}};
  localparam logic [FW:0] FMAX   = {1'b1, {FW{1'b0}}};
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_DROP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_SEND} rd_state_e;
  logic [EW-1:0] mem [2**AW];
  wr_state_e wr_q, wr_d;
  rd_state_e rd_q, rd_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q, used;
  logic [FW:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_q, drop_d;
  logic [EW-1:0] ram_q, o0_q, o0_d, o1_q, o1_d;
  logic [1:0] ocnt_q, ocnt_d;
  logic rdy_q, ram_vld_q, full, acc, ovf, we, commit, drop, pop, pop_last, push, fetch;
  assign used = wr_ptr_q - rd_ptr_q;
  assign full = used == DEPTH;
  // mid-frame the port stays open even when full: that beat is swallowed by the overflow path
  assign s_axis_tready = rdy_q & (wr_q != WR_IDLE | !(full | frame_cnt_q == FMAX));
  assign acc = s_axis_tvalid & s_axis_tready;
  assign ovf = (wr_q == WR_DATA & full) | (wr_q == WR_IDLE & used == ALMOST & !s_axis_tlast);
  always_comb begin
    wr_d = wr_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    we = 1'b0;
    commit = 1'b0;
    drop = 1'b0;
    if (acc) begin
      if (wr_q == WR_DROP || ovf) begin
        wr_ptr_d = commit_q;
        drop = s_axis_tlast;
        wr_d = s_axis_tlast ? WR_IDLE : WR_DROP;
      end else begin
        we = 1'b1;
        commit = s_axis_tlast & !s_axis_tuser;
        drop = s_axis_tlast & s_axis_tuser;
        wr_ptr_d = drop ? commit_q : wr_ptr_q + 1'b1;
        commit_d = commit ? wr_ptr_q + 1'b1 : commit_q;
        wr_d = s_axis_tlast ? WR_IDLE : WR_DATA;
      end
    end
  end
  // ram_vld_q plus the two skid entries never exceed two beats, so a fetch is always absorbed
  assign pop = tx_axis_mac_tvalid & tx_axis_mac_tready;
  assign pop_last = pop & o0_q[EW-1];
  assign push = ram_vld_q;
  assign fetch = rd_ptr_q != commit_q & ({1'b0, ram_vld_q} + ocnt_q - {1'b0, pop}) <= 2'd1;
  always_comb begin
    rd_d = rd_q == RD_IDLE ? (frame_cnt_q != '0 ? RD_SEND : RD_IDLE) : (push & ram_q[EW-1] ? RD_IDLE : RD_SEND);
    ocnt_d = ocnt_q + {1'b0, push} - {1'b0, pop};
    o0_d = (pop & ocnt_q == 2'd2) ? o1_q : (push & (ocnt_q == 2'd0 | pop)) ? ram_q : o0_q;
    o1_d = (push & (ocnt_q - {1'b0, pop}) == 2'd1) ? ram_q : o1_q;
    frame_cnt_d = commit == pop_last ? frame_cnt_q : commit ? frame_cnt_q + 1'b1 : frame_cnt_q - 1'b1;
    drop_d = drop & drop_q != 16'hFFFF ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge tx_clk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (fetch) ram_q <= mem[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      wr_q <= WR_IDLE;
      rd_q <= RD_IDLE;
      wr_ptr_q <= '0;
      commit_q <= '0;
      rd_ptr_q <= '0;
      frame_cnt_q <= '0;
      drop_q <= '0;
      rdy_q <= 1'b0;
      ram_vld_q <= 1'b0;
      ocnt_q <= '0;
      o0_q <= '0;
      o1_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      rd_ptr_q <= fetch ? rd_ptr_q + 1'b1 : rd_ptr_q;
      frame_cnt_q <= frame_cnt_d;
      drop_q <= drop_d;
      rdy_q <= 1'b1;
      ram_vld_q <= fetch;
      ocnt_q <= ocnt_d;
      o0_q <= o0_d;
      o1_q <= o1_d;
    end
  end
  assign tx_axis_mac_tdata = o0_q[C_DATA_WIDTH-1:0];
  assign tx_axis_mac_tkeep = o0_q[C_DATA_WIDTH +: KW];
  assign tx_axis_mac_tlast = o0_q[EW-1];
  assign tx_axis_mac_tvalid = ocnt_q != 2'd0;
  assign tx_axis_mac_tuser = 1'b0;
  assign frame_drop_cnt = drop_q;
  assign fifo_level = used;
endmodule
